sprite_motion: RTL and testbench

Per-sprite position/velocity engine, directly downstream of the game master FSM. Consumes its write_xy / write_dxy / enable_update controls and returns sprite_within_screen to it. Holds signed X/Y position and signed DX/DY velocity, and advances position by velocity once per UPDATE_DIV frame strobes. Exports position to the sprite display and collision logic.

---
 rtl/sprite_motion_if.sv | 34 +++
 rtl/sprite_motion.sv | 143 ++++++++++++++
 tb/tb_sprite_motion.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_if.sv
// Control and status bundle between the game master FSM (master) and one
// sprite motion engine (slave).
interface sprite_motion_if #(
  parameter int X_W = 11,
  parameter int Y_W = 11,
  parameter int D_W = 4
);
  logic                  sprite_write_xy;
  logic signed [X_W-1:0] sprite_write_x;
  logic signed [Y_W-1:0] sprite_write_y;
  logic                  sprite_write_dxy;
  logic signed [D_W-1:0] sprite_write_dx;
  logic signed [D_W-1:0] sprite_write_dy;
  logic                  sprite_enable_update;
  logic                  frame_strobe;
  logic signed [X_W-1:0] sprite_x;
  logic signed [Y_W-1:0] sprite_y;
  logic                  sprite_within_screen;
  logic                  sprite_step_done;

  modport master (
    output sprite_write_xy, sprite_write_x, sprite_write_y,
    output sprite_write_dxy, sprite_write_dx, sprite_write_dy,
    output sprite_enable_update, frame_strobe,
    input  sprite_x, sprite_y, sprite_within_screen, sprite_step_done
  );

  modport slave (
    input  sprite_write_xy, sprite_write_x, sprite_write_y,
    input  sprite_write_dxy, sprite_write_dx, sprite_write_dy,
    input  sprite_enable_update, frame_strobe,
    output sprite_x, sprite_y, sprite_within_screen, sprite_step_done
  );
endinterface

// File: rtl/sprite_motion.sv
// Per-sprite position/velocity engine: advances a saturating signed position by
// its velocity once every UPDATE_DIV frame strobes and reports screen overlap.
module sprite_motion #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPRITE_W   = 8,
  parameter int SPRITE_H   = 8,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int D_W        = 4,
  parameter int UPDATE_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  sprite_motion_if.slave  bus
);

  localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic signed [X_W-1:0] X_LO     = X_W'(-SPRITE_W);
  localparam logic signed [X_W-1:0] X_HI     = X_W'(SCREEN_W);
  localparam logic signed [Y_W-1:0] Y_LO     = Y_W'(-SPRITE_H);
  localparam logic signed [Y_W-1:0] Y_HI     = Y_W'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic signed [X_W-1:0] r_x;
  logic signed [Y_W-1:0] r_y;
  logic signed [D_W-1:0] r_dx;
  logic signed [D_W-1:0] r_dy;
  logic                  r_within;
  logic                  r_step_done;

  logic signed [X_W-1:0] w_x_step;
  logic signed [Y_W-1:0] w_y_step;
  logic                  w_within;

  // One extra bit of headroom; disagreeing top bits mean the sum left the range.
  function automatic logic signed [X_W-1:0] sat_add_x(
    input logic signed [X_W-1:0] a,
    input logic signed [D_W-1:0] d
  );
    logic signed [X_W:0] sum;
    sum = {a[X_W-1], a} + {{(X_W+1-D_W){d[D_W-1]}}, d};
    if (sum[X_W] != sum[X_W-1]) begin
      return sum[X_W] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
    end else begin
      return sum[X_W-1:0];
    end
  endfunction

  function automatic logic signed [Y_W-1:0] sat_add_y(
    input logic signed [Y_W-1:0] a,
    input logic signed [D_W-1:0] d
  );
    logic signed [Y_W:0] sum;
    sum = {a[Y_W-1], a} + {{(Y_W+1-D_W){d[D_W-1]}}, d};
    if (sum[Y_W] != sum[Y_W-1]) begin
      return sum[Y_W] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
    end else begin
      return sum[Y_W-1:0];
    end
  endfunction

  assign w_x_step = sat_add_x(r_x, r_dx);
  assign w_y_step = sat_add_y(r_y, r_dy);
  assign w_within = (r_x > X_LO) && (r_x < X_HI) && (r_y > Y_LO) && (r_y < Y_HI);

  // Motion FSM, frame divider, position/velocity registers and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_div       <= {DIV_W{1'b0}};
      r_x         <= {X_W{1'b0}};
      r_y         <= {Y_W{1'b0}};
      r_dx        <= {D_W{1'b0}};
      r_dy        <= {D_W{1'b0}};
      r_within    <= 1'b1;
      r_step_done <= 1'b0;
    end else begin
      r_within    <= w_within;
      r_step_done <= 1'b0;
      if (bus.sprite_write_dxy) begin
        r_dx <= bus.sprite_write_dx;
        r_dy <= bus.sprite_write_dy;
      end
      case (r_state)
        S_IDLE: begin
          r_div <= {DIV_W{1'b0}};
          if (bus.sprite_enable_update) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.sprite_enable_update) begin
            r_state <= S_IDLE;
            r_div   <= {DIV_W{1'b0}};
          end else if (bus.frame_strobe) begin
            if (r_div == DIV_LAST) begin
              r_div   <= {DIV_W{1'b0}};
              r_state <= S_STEP;
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
        end
        S_STEP: begin
          // A simultaneous position load wins and the step is dropped.
          if (!bus.sprite_write_xy) begin
            r_x <= w_x_step;
            r_y <= w_y_step;
          end
          r_step_done <= 1'b1;
          r_state     <= S_CHECK;
        end
        S_CHECK: begin
          r_state <= bus.sprite_enable_update ? S_RUN : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_div   <= {DIV_W{1'b0}};
        end
      endcase
      if (bus.sprite_write_xy) begin
        r_x <= bus.sprite_write_x;
        r_y <= bus.sprite_write_y;
      end
    end
  end

  assign bus.sprite_x             = r_x;
  assign bus.sprite_y             = r_y;
  assign bus.sprite_within_screen = r_within;
  assign bus.sprite_step_done     = r_step_done;

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: two engines (UPDATE_DIV 1 and 3) share one stimulus
// stream and are checked against a per-frame arithmetic reference model.
module tb_sprite_motion;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 8;
  localparam int P_MIN    = -1024;
  localparam int P_MAX    = 1023;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sprite_motion_if #(.X_W(11), .Y_W(11), .D_W(4)) if1 ();
  sprite_motion_if #(.X_W(11), .Y_W(11), .D_W(4)) if3 ();

  assign if3.sprite_write_xy      = if1.sprite_write_xy;
  assign if3.sprite_write_x       = if1.sprite_write_x;
  assign if3.sprite_write_y       = if1.sprite_write_y;
  assign if3.sprite_write_dxy     = if1.sprite_write_dxy;
  assign if3.sprite_write_dx      = if1.sprite_write_dx;
  assign if3.sprite_write_dy      = if1.sprite_write_dy;
  assign if3.sprite_enable_update = if1.sprite_enable_update;
  assign if3.frame_strobe         = if1.frame_strobe;

  sprite_motion #(.UPDATE_DIV(1)) u_div1 (.clk(clk), .rst(rst), .bus(if1));
  sprite_motion #(.UPDATE_DIV(3)) u_div3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 follows the divide-by-1 engine, index 1 divide-by-3.
  int m_x[2], m_y[2], m_dx[2], m_dy[2];
  int m_strobes[2];     // strobes counted toward the next step
  int m_pending[2];     // 2: step commits at next edge, 1: step finishing, 0: none
  bit m_enabled[2];
  bit m_within[2], m_done[2];
  int div_of[2] = '{1, 3};

  function automatic int clamp(input int v);
    return (v < P_MIN) ? P_MIN : ((v > P_MAX) ? P_MAX : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_dx[k] = 0; m_dy[k] = 0;
      m_strobes[k] = 0; m_pending[k] = 0; m_enabled[k] = 1'b0;
      m_within[k] = 1'b1; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit wxy, input int wx, input int wy, input bit wdxy,
                            input int wdx, input int wdy, input bit en, input bit stb);
    for (int k = 0; k < 2; k++) begin
      int nx;
      int ny;
      nx = m_x[k];
      ny = m_y[k];
      m_within[k] = (m_x[k] > -SPRITE_W) && (m_x[k] < SCREEN_W) &&
                    (m_y[k] > -SPRITE_H) && (m_y[k] < SCREEN_H);
      m_done[k] = 1'b0;
      if (m_pending[k] == 2) begin
        nx = clamp(m_x[k] + m_dx[k]);
        ny = clamp(m_y[k] + m_dy[k]);
        m_done[k] = 1'b1;
        m_pending[k] = 1;
      end else if (m_pending[k] == 1) begin
        m_pending[k] = 0;
        m_enabled[k] = en;
      end else if (!m_enabled[k] || !en) begin
        m_enabled[k] = en;
        m_strobes[k] = 0;
      end else if (stb) begin
        m_strobes[k]++;
        if (m_strobes[k] == div_of[k]) begin
          m_strobes[k] = 0;
          m_pending[k] = 2;
        end
      end
      if (wxy) begin
        nx = wx;
        ny = wy;
      end
      if (wdxy) begin
        m_dx[k] = wdx;
        m_dy[k] = wdy;
      end
      m_x[k] = nx;
      m_y[k] = ny;
    end
  endtask

  task automatic tick();
    bit wxy  = if1.sprite_write_xy;
    int wx   = if1.sprite_write_x;
    int wy   = if1.sprite_write_y;
    bit wdxy = if1.sprite_write_dxy;
    int wdx  = if1.sprite_write_dx;
    int wdy  = if1.sprite_write_dy;
    bit en   = if1.sprite_enable_update;
    bit stb  = if1.frame_strobe;
    @(posedge clk);
    if (rst) model_edge(wxy, wx, wy, wdxy, wdx, wdy, en, stb);
    else     model_reset();
    #1;
  endtask

  task automatic clear_inputs();
    if1.sprite_write_xy = 1'b0;  if1.sprite_write_x = 11'sd0; if1.sprite_write_y = 11'sd0;
    if1.sprite_write_dxy = 1'b0; if1.sprite_write_dx = 4'sd0; if1.sprite_write_dy = 4'sd0;
    if1.sprite_enable_update = 1'b0;
    if1.frame_strobe = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic setup(input int x, input int y, input int dx, input int dy);
    if1.sprite_write_xy = 1'b1;  if1.sprite_write_x = 11'(x);  if1.sprite_write_y = 11'(y);
    if1.sprite_write_dxy = 1'b1; if1.sprite_write_dx = 4'(dx); if1.sprite_write_dy = 4'(dy);
    if1.sprite_enable_update = 1'b1;
    tick();
    if1.sprite_write_xy = 1'b0;
    if1.sprite_write_dxy = 1'b0;
  endtask

  task automatic strobe();
    if1.frame_strobe = 1'b1;
    tick();
    if1.frame_strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    setup(37, -5, 2, 1);
    repeat (3) begin strobe(); tick(); tick(); end
    strobe();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (if1.sprite_x !== 11'sd0 || if1.sprite_y !== 11'sd0) begin
      n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", if1.sprite_x, if1.sprite_y);
    end
    n_checks++;
    if (if1.sprite_within_screen !== 1'b1 || if1.sprite_step_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got within=%b done=%b want 1/0",
                         if1.sprite_within_screen, if1.sprite_step_done);
    end
    n_checks++;
    if (if3.sprite_x !== 11'sd0 || if3.sprite_within_screen !== 1'b1) begin
      n_fail++; $display("FAIL reset_div3: got x=%0d within=%b want 0/1",
                         if3.sprite_x, if3.sprite_within_screen);
    end
    tick();
    rst = 1'b1;
    clear_inputs();
    repeat (5) begin strobe(); tick(); tick(); end
    n_checks++;
    if (if1.sprite_x !== 11'sd0 || if3.sprite_x !== 11'sd0 || if1.sprite_step_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got x1=%0d x3=%0d done=%b want 0/0/0",
                         if1.sprite_x, if3.sprite_x, if1.sprite_step_done);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    setup(100, 50, 3, -2);
    strobe();
    tick();
    n_checks++;
    if (if1.sprite_x !== 11'sd103 || if1.sprite_y !== 11'sd48 || if1.sprite_step_done !== 1'b1) begin
      n_fail++; $display("FAIL single_step: got (%0d,%0d) done=%b want (103,48) done=1",
                         if1.sprite_x, if1.sprite_y, if1.sprite_step_done);
    end
    n_checks++;
    if (if3.sprite_x !== 11'sd100 || if3.sprite_step_done !== 1'b0) begin
      n_fail++; $display("FAIL single_step_div3: got x=%0d done=%b want 100/0",
                         if3.sprite_x, if3.sprite_step_done);
    end
    tick();
    n_checks++;
    if (if1.sprite_step_done !== 1'b0 || if1.sprite_within_screen !== 1'b1) begin
      n_fail++; $display("FAIL single_done_pulse: got done=%b within=%b want 0/1",
                         if1.sprite_step_done, if1.sprite_within_screen);
    end
  endtask

  task automatic test_divider();
    int x3;
    do_reset();
    setup(0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      strobe();
      tick();
      x3 = if3.sprite_x;
      n_checks++;
      if (x3 !== i / 3 || if1.sprite_x !== 11'(i)) begin
        n_fail++; $display("FAIL divider_strobe%0d: got x3=%0d x1=%0d want %0d/%0d",
                           i, x3, if1.sprite_x, i / 3, i);
      end
      tick();
    end
    repeat (2) begin strobe(); tick(); tick(); end
    if1.sprite_enable_update = 1'b0;
    tick();
    if1.sprite_enable_update = 1'b1;
    tick();
    for (int j = 1; j <= 3; j++) begin
      strobe();
      tick();
      x3 = if3.sprite_x;
      n_checks++;
      if (x3 !== ((j == 3) ? 3 : 2)) begin
        n_fail++; $display("FAIL divider_restart%0d: got x3=%0d want %0d", j, x3, (j == 3) ? 3 : 2);
      end
      tick();
    end
  endtask

  task automatic test_leave_screen();
    int ex[3] = '{-2, -6, -10};
    bit ew[3] = '{1'b1, 1'b1, 1'b0};
    int x1;
    do_reset();
    setup(2, 0, -4, 0);
    for (int i = 0; i < 3; i++) begin
      strobe();
      tick();
      x1 = if1.sprite_x;
      n_checks++;
      if (x1 !== ex[i] || if1.sprite_within_screen !== 1'b1) begin
        n_fail++; $display("FAIL leave_step%0d: got x=%0d within=%b want %0d/1",
                           i, x1, if1.sprite_within_screen, ex[i]);
      end
      tick();
      n_checks++;
      if (if1.sprite_within_screen !== ew[i]) begin
        n_fail++; $display("FAIL leave_within%0d: got %b want %b", i, if1.sprite_within_screen, ew[i]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    setup(0, 0, 5, 0);
    strobe();
    if1.sprite_write_xy = 1'b1; if1.sprite_write_x = 11'sd10; if1.sprite_write_y = 11'sd10;
    if1.sprite_write_dxy = 1'b1; if1.sprite_write_dx = 4'sd1; if1.sprite_write_dy = 4'sd0;
    tick();
    if1.sprite_write_xy = 1'b0; if1.sprite_write_dxy = 1'b0;
    n_checks++;
    if (if1.sprite_x !== 11'sd10 || if1.sprite_y !== 11'sd10 || if1.sprite_step_done !== 1'b1) begin
      n_fail++; $display("FAIL prio_load: got (%0d,%0d) done=%b want (10,10) done=1",
                         if1.sprite_x, if1.sprite_y, if1.sprite_step_done);
    end
    tick();
    strobe();
    tick();
    n_checks++;
    if (if1.sprite_x !== 11'sd11) begin
      n_fail++; $display("FAIL prio_new_dx: got %0d want 11", if1.sprite_x);
    end
    tick();
    strobe();
    if1.sprite_write_dxy = 1'b1; if1.sprite_write_dx = 4'sd6;
    tick();
    if1.sprite_write_dxy = 1'b0;
    n_checks++;
    if (if1.sprite_x !== 11'sd12) begin
      n_fail++; $display("FAIL prio_old_dx: got %0d want 12", if1.sprite_x);
    end
    tick();
    strobe();
    tick();
    n_checks++;
    if (if1.sprite_x !== 11'sd18) begin
      n_fail++; $display("FAIL prio_next_dx: got %0d want 18", if1.sprite_x);
    end
  endtask

  task automatic test_saturation();
    int x1;
    do_reset();
    setup(1020, 0, 7, 0);
    repeat (3) begin
      strobe();
      tick();
      x1 = if1.sprite_x;
      n_checks++;
      if (x1 !== 1023) begin
        n_fail++; $display("FAIL sat_pos: got %0d want 1023", x1);
      end
      tick();
      n_checks++;
      if (if1.sprite_within_screen !== 1'b0) begin
        n_fail++; $display("FAIL sat_within: got %b want 0", if1.sprite_within_screen);
      end
    end
    setup(-1020, 0, -8, 0);
    repeat (2) begin strobe(); tick(); tick(); end
    x1 = if1.sprite_x;
    n_checks++;
    if (x1 !== -1024) begin
      n_fail++; $display("FAIL sat_neg: got %0d want -1024", x1);
    end
  endtask

  task automatic test_random();
    int ax;
    int ay;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if1.sprite_write_xy = ($urandom_range(0, 15) == 0);
      if1.sprite_write_x  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                        : 11'(int'($urandom_range(0, 60)) - 20);
      if1.sprite_write_y  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                        : 11'(int'($urandom_range(0, 60)) - 20);
      if1.sprite_write_dxy = ($urandom_range(0, 7) == 0);
      if1.sprite_write_dx  = 4'($urandom_range(0, 15));
      if1.sprite_write_dy  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) if1.sprite_enable_update = ~if1.sprite_enable_update;
      if1.frame_strobe = ($urandom_range(0, 2) == 0);
      tick();
      ax = if1.sprite_x;
      ay = if1.sprite_y;
      n_checks++;
      if (ax !== m_x[0] || ay !== m_y[0] || if1.sprite_within_screen !== m_within[0] ||
          if1.sprite_step_done !== m_done[0]) begin
        n_fail++; $display("FAIL rand_div1 c=%0d: got (%0d,%0d,%b,%b) want (%0d,%0d,%b,%b)", c, ax, ay,
                           if1.sprite_within_screen, if1.sprite_step_done, m_x[0], m_y[0], m_within[0], m_done[0]);
      end
      ax = if3.sprite_x;
      ay = if3.sprite_y;
      n_checks++;
      if (ax !== m_x[1] || ay !== m_y[1] || if3.sprite_within_screen !== m_within[1] ||
          if3.sprite_step_done !== m_done[1]) begin
        n_fail++; $display("FAIL rand_div3 c=%0d: got (%0d,%0d,%b,%b) want (%0d,%0d,%b,%b)", c, ax, ay,
                           if3.sprite_within_screen, if3.sprite_step_done, m_x[1], m_y[1], m_within[1], m_done[1]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_step();
    test_divider();
    test_leave_screen();
    test_priority();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
